// File: rtl/bdu_bit_feeder_if.sv
// Handshake and bit-stream signals between a word source, the bit feeder and the BDU array.
// The master drives dimension words and batch_done; the slave (the feeder) drives the streams.
interface bdu_bit_feeder_if #(
    parameter int unsigned NUM_BDU = 8,
    parameter int unsigned B       = 8,
    parameter int unsigned BW      = $clog2(B)
);
    logic               in_valid;
    logic               in_ready;
    logic [B-1:0]       in_q;
    logic [NUM_BDU*B-1:0] in_r;
    logic               in_last;
    logic [NUM_BDU-1:0] in_lane_mask;
    logic               batch_done;
    logic [NUM_BDU-1:0] bdu_valid;
    logic               bdu_q_bit;
    logic [NUM_BDU-1:0] bdu_r_bit;
    logic [1:0]         bdu_code;
    logic [BW-1:0]      bdu_b;
    logic               busy;

    modport master (
        output in_valid, in_q, in_r, in_last, in_lane_mask, batch_done,
        input  in_ready, bdu_valid, bdu_q_bit, bdu_r_bit, bdu_code, bdu_b, busy
    );

    modport slave (
        input  in_valid, in_q, in_r, in_last, in_lane_mask, batch_done,
        output in_ready, bdu_valid, bdu_q_bit, bdu_r_bit, bdu_code, bdu_b, busy
    );
endinterface

// File: rtl/bdu_bit_feeder.sv
// Serializes query/reference dimension words MSB-first into per-lane BDU bit streams,
// with a one-word holding buffer so consecutive dimensions stream without gaps.
module bdu_bit_feeder #(
    parameter int unsigned NUM_BDU = 8,
    parameter int unsigned B       = 8,
    parameter int unsigned BW      = $clog2(B)
) (
    input logic clk,
    input logic rst,
    bdu_bit_feeder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StShift, StWaitDone} state_e;

    localparam logic [1:0] CodeMid      = 2'b00;
    localparam logic [1:0] CodeStart    = 2'b01;
    localparam logic [1:0] CodeDimEnd   = 2'b10;
    localparam logic [1:0] CodeBatchEnd = 2'b11;
    localparam logic [BW-1:0] BcTop     = BW'(B - 1);

    state_e state_q, state_d;

    logic                        rdy_en_q;
    logic                        next_first_q;
    logic                        pend_full_q;
    logic                        pend_last_q;
    logic                        pend_first_q;
    logic [B-1:0]                pend_query_q;
    logic [NUM_BDU-1:0][B-1:0]   pend_ref_q;
    logic                        sh_last_q;
    logic                        sh_first_q;
    logic [B-1:0]                sh_query_q;
    logic [NUM_BDU-1:0][B-1:0]   sh_ref_q;
    logic [BW-1:0]               bc_q;
    logic [NUM_BDU-1:0]          mask_q;

    logic accept;
    logic load_sh;

    // rdy_en_q keeps in_ready low during reset and for the cycle it is released.
    assign bus.in_ready = rdy_en_q && !pend_full_q;
    assign bus.busy     = (state_q != StIdle);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        load_sh = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pend_full_q) begin
                    load_sh = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bc_q == '0) begin
                    if (sh_last_q) begin
                        state_d = StWaitDone;
                    end else if (pend_full_q) begin
                        load_sh = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StWaitDone: begin
                if (bus.batch_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            rdy_en_q     <= 1'b0;
            next_first_q <= 1'b1;
            pend_full_q  <= 1'b0;
            pend_last_q  <= 1'b0;
            pend_first_q <= 1'b0;
            pend_query_q <= '0;
            pend_ref_q   <= '0;
            sh_last_q    <= 1'b0;
            sh_first_q   <= 1'b0;
            sh_query_q   <= '0;
            sh_ref_q     <= '0;
            bc_q         <= '0;
            mask_q       <= '0;
        end else begin
            state_q     <= state_d;
            rdy_en_q    <= 1'b1;
            pend_full_q <= accept || (pend_full_q && !load_sh);
            // A word opens a batch exactly when the previously accepted word closed one.
            if (accept) begin
                pend_query_q <= bus.in_q;
                pend_ref_q   <= bus.in_r;
                pend_last_q  <= bus.in_last;
                pend_first_q <= next_first_q;
                next_first_q <= bus.in_last;
            end
            if (load_sh) begin
                sh_query_q <= pend_query_q;
                sh_ref_q   <= pend_ref_q;
                sh_last_q  <= pend_last_q;
                sh_first_q <= pend_first_q;
                bc_q       <= BcTop;
                if (pend_first_q) begin
                    mask_q <= bus.in_lane_mask;
                end
            end else if (state_q == StShift) begin
                bc_q <= (bc_q == '0) ? BcTop : bc_q - 1'b1;
            end
        end
    end

    always_comb begin
        bus.bdu_valid = '0;
        bus.bdu_q_bit = 1'b0;
        bus.bdu_r_bit = '0;
        bus.bdu_code  = CodeMid;
        bus.bdu_b     = '0;
        if (state_q == StShift) begin
            bus.bdu_valid = mask_q;
            bus.bdu_q_bit = sh_query_q[bc_q];
            bus.bdu_b     = bc_q;
            for (int i = 0; i < int'(NUM_BDU); i++) begin
                bus.bdu_r_bit[i] = sh_ref_q[i][bc_q];
            end
            if (bc_q == BcTop && sh_first_q) begin
                bus.bdu_code = CodeStart;
            end else if (bc_q == '0) begin
                bus.bdu_code = sh_last_q ? CodeBatchEnd : CodeDimEnd;
            end
        end
    end

endmodule

// File: tb/tb_bdu_bit_feeder.sv
// Directed bench for bdu_bit_feeder: accepted words go to a scoreboard queue and the
// serialized bit stream is rebuilt and compared word by word.
module tb_bdu_bit_feeder;

    localparam int unsigned NB = 2;
    localparam int unsigned BB = 8;

    typedef struct {
        logic [BB-1:0]    q;
        logic [NB*BB-1:0] r;
        logic             last;
        logic             first;
        logic [NB-1:0]    mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bdu_bit_feeder_if #(.NUM_BDU(NB), .B(BB)) ifc ();

    bdu_bit_feeder #(.NUM_BDU(NB), .B(BB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    exp_t sb[$];
    logic next_first = 1'b1;
    logic [NB-1:0] batch_mask = '1;
    int acc_cyc = 0, start_cyc = 0, be_cyc = 0, p_cyc = 0;
    int be_count = 0, words_done = 0, cur_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [BB-1:0] q, input logic [NB*BB-1:0] r, input logic last);
        logic ok;
        exp_t e;
        ok = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_q     = q;
        ifc.in_r     = r;
        ifc.in_last  = last;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = (ifc.in_ready === 1'b1);
            @(posedge clk);
            step(1);
        end
        chk("send_accepted", {31'd0, ok}, 32'd1);
        if (ok) begin
            e.q = q; e.r = r; e.last = last; e.first = next_first; e.mask = batch_mask;
            sb.push_back(e);
            next_first = last;
            acc_cyc = cyc;
        end
    endtask

    task automatic pulse_done();
        ifc.batch_done = 1'b1;
        p_cyc = cyc;
        step(1);
        ifc.batch_done = 1'b0;
    endtask

    task automatic wait_be(input int n);
        for (int i = 0; i < 300 && be_count < n; i++) step(1);
        chk("batch_end_reached", {31'd0, be_count >= n}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {ifc.in_ready, ifc.busy, ifc.bdu_valid, ifc.bdu_q_bit, ifc.bdu_r_bit,
                  ifc.bdu_code, ifc.bdu_b}, 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: rebuilds each serialized word and checks it against the scoreboard head.
    initial begin : monitor
        int mcnt;
        int k;
        logic have;
        logic [1:0] ecode;
        exp_t cur;
        mcnt = 0;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mcnt = 0;
            end else if (ifc.bdu_valid != '0) begin
                if (mcnt == 0) begin
                    have = (sb.size() != 0);
                    chk("sb_has_word", {31'd0, have}, 32'd1);
                    if (have) cur = sb.pop_front();
                end
                if (have) begin
                    k = BB - 1 - mcnt;
                    if (mcnt == 0 && cur.first) ecode = 2'b01;
                    else if (mcnt == BB - 1) ecode = cur.last ? 2'b11 : 2'b10;
                    else ecode = 2'b00;
                    chk("q_bit", {31'd0, ifc.bdu_q_bit}, {31'd0, cur.q[k]});
                    chk("r_bit", {30'd0, ifc.bdu_r_bit}, {30'd0, cur.r[BB + k], cur.r[k]});
                    chk("bit_index", {29'd0, ifc.bdu_b}, k);
                    chk("lane_valid", {30'd0, ifc.bdu_valid}, {30'd0, cur.mask});
                    chk("code", {30'd0, ifc.bdu_code}, {30'd0, ecode});
                end
                if (ifc.bdu_code == 2'b01) start_cyc = cyc;
                if (ifc.bdu_code == 2'b11) begin
                    be_count++;
                    be_cyc = cyc;
                end
                cur_b = int'(ifc.bdu_b);
                if (mcnt == BB - 1) begin
                    mcnt = 0;
                    words_done++;
                end else begin
                    mcnt++;
                end
            end else begin
                chk("idle_outputs_zero", {ifc.bdu_q_bit, ifc.bdu_r_bit, ifc.bdu_code, ifc.bdu_b},
                    32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int w0;
        ifc.in_valid     = 1'b0;
        ifc.in_q         = '0;
        ifc.in_r         = '0;
        ifc.in_last      = 1'b0;
        ifc.in_lane_mask = 2'b11;
        ifc.batch_done   = 1'b0;

        // Reset state and release timing.
        step(3);
        chk_all_zero("reset_outputs");
        rst = 1'b1;
        step(1);
        chk("ready_after_release", {31'd0, ifc.in_ready}, 32'd1);

        // Single-dimension batch with the documented pattern.
        batch_mask = 2'b11; ifc.in_lane_mask = 2'b11;
        send(8'hA5, {8'hFF, 8'h3C}, 1'b1);
        ifc.in_valid = 1'b0;
        wait_be(1);
        chk("msb_latency", start_cyc - acc_cyc, 32'd1);
        chk("lsb_latency", be_cyc - acc_cyc, 32'd8);
        step(1);
        chk("wait_done_busy", {31'd0, ifc.busy}, 32'd1);
        chk("wait_done_valid", {30'd0, ifc.bdu_valid}, 32'd0);
        pulse_done();
        chk("idle_after_done", {31'd0, ifc.busy}, 32'd0);

        // Three dimensions offered back to back; done coinciding with BATCH_END is ignored.
        send(8'h12, {8'h34, 8'h56}, 1'b0);
        send(8'h9E, {8'h01, 8'h80}, 1'b0);
        send(8'h7F, {8'hC3, 8'h5A}, 1'b1);
        ifc.in_valid = 1'b0;
        wait_be(2);
        chk("gapless_span", be_cyc - start_cyc, 32'd23);
        pulse_done();
        chk("min_wait_busy", {31'd0, ifc.busy}, 32'd1);
        chk("min_wait_valid", {30'd0, ifc.bdu_valid}, 32'd0);
        step(2);
        chk("still_waiting", {31'd0, ifc.busy}, 32'd1);
        pulse_done();
        chk("released", {31'd0, ifc.busy}, 32'd0);

        // Done during SHIFT has no effect; next batch accepted during WAIT_DONE.
        send(8'hE1, {8'h0F, 8'hF0}, 1'b0);
        send(8'h3B, {8'hAA, 8'h55}, 1'b1);
        ifc.in_valid = 1'b0;
        pulse_done();
        wait_be(3);
        step(1);
        batch_mask = 2'b10; ifc.in_lane_mask = 2'b10;
        send(8'hC6, {8'h99, 8'h66}, 1'b0);
        ifc.in_valid = 1'b1; ifc.in_q = 8'h2D; ifc.in_r = {8'hB4, 8'h4B}; ifc.in_last = 1'b1;
        chk("backpressure_0", {31'd0, ifc.in_ready}, 32'd0);
        step(1);
        chk("backpressure_1", {31'd0, ifc.in_ready}, 32'd0);
        step(1);
        chk("backpressure_2", {31'd0, ifc.in_ready}, 32'd0);
        step(1);
        pulse_done();
        chk("backpressure_idle", {31'd0, ifc.in_ready}, 32'd0);
        send(8'h2D, {8'hB4, 8'h4B}, 1'b1);
        ifc.in_valid = 1'b0;
        wait_be(4);
        chk("start_after_done", start_cyc - p_cyc, 32'd2);
        step(1);
        pulse_done();

        // Lane mask 01, changed mid-batch, then mask 10.
        batch_mask = 2'b01; ifc.in_lane_mask = 2'b01;
        send(8'h81, {8'h18, 8'h24}, 1'b0);
        send(8'h42, {8'hE7, 8'h7E}, 1'b1);
        ifc.in_valid = 1'b0;
        ifc.in_lane_mask = 2'b11;
        wait_be(5);
        step(1);
        pulse_done();
        batch_mask = 2'b10; ifc.in_lane_mask = 2'b10;
        send(8'h6C, {8'hD2, 8'h2D}, 1'b1);
        ifc.in_valid = 1'b0;
        wait_be(6);
        step(1);
        pulse_done();

        // Reset at bit 3 of dimension 2 with the holding buffer full.
        batch_mask = 2'b11; ifc.in_lane_mask = 2'b11;
        w0 = words_done;
        send(8'hF1, {8'h1F, 8'h8E}, 1'b0);
        send(8'h0E, {8'hE0, 8'h71}, 1'b0);
        send(8'hB7, {8'h7B, 8'hDD}, 1'b1);
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 100 && !(words_done == w0 + 1 && cur_b == 3); i++) step(1);
        chk("reached_dim2_bit3", {31'd0, words_done == w0 + 1 && cur_b == 3}, 32'd1);
        chk("pend_full_at_reset", {31'd0, ifc.in_ready}, 32'd0);
        rst = 1'b0;
        sb.delete();
        next_first = 1'b1;
        step(1);
        chk_all_zero("mid_reset_outputs");
        rst = 1'b1;
        step(1);
        chk("ready_after_mid_reset", {31'd0, ifc.in_ready}, 32'd1);
        send(8'h5E, {8'hA1, 8'h3F}, 1'b1);
        ifc.in_valid = 1'b0;
        wait_be(7);
        step(1);
        pulse_done();
        step(2);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bdu_bit_feeder.md
# bdu_bit_feeder

Bit-serial front end for the BDU array. It accepts one dimension word per handshake: a B-bit query value plus NUM_BDU B-bit reference values. It serializes each word MSB-first into per-lane `{valid, q_bit, r_bit, code, b}` streams that drive the BDU array's `BDU_inputs`. A one-word holding buffer keeps the serializer gapless across dimensions. A batch ends on the word tagged `in_last`; the feeder then stalls until the array reports completion.

## Interface
Parameters:
- `NUM_BDU`, default 8: number of BDU lanes.
- `B`, default 8: bits per dimension word. Must be at least 2.
- `BW`, default `$clog2(B)`: width of the bit-index field.

Ports:
- `clk` input 1: the only clock.
- `rst` input 1: reset, synchronous, active-low.
- `in_valid` input 1: a dimension word is offered.
- `in_ready` output 1: the holding buffer is empty.
- `in_q` input B: query value for this dimension.
- `in_r` input NUM_BDU*B: reference values; lane i occupies `[i*B +: B]`.
- `in_last` input 1: this word is the final dimension of the batch.
- `in_lane_mask` input NUM_BDU: lanes active for the batch. Sampled only on the first word of a batch.
- `batch_done` input 1: single-cycle pulse from the BDU array when all lanes are complete.
- `bdu_valid` output NUM_BDU: per-lane valid.
- `bdu_q_bit` output 1: current query bit, broadcast to all lanes.
- `bdu_r_bit` output NUM_BDU: current reference bit per lane.
- `bdu_code` output 2: bit tag.
  - 01 START: first bit of the first dimension.
  - 00 MID.
  - 10 DIM_END: last bit of a non-final dimension.
  - 11 BATCH_END: last bit of the final dimension.
- `bdu_b` output BW: index of the current bit, counting from B-1 down to 0.
- `busy` output 1: the block is in SHIFT or WAIT_DONE.

## Operation
- **Storage**
  - Holding register `pend`: the word, its last flag, and a full flag.
  - Shift register `sh`: query, references, last flag, and a first-of-batch flag.
  - Bit counter `bc` and lane mask register `mask`.
- **Handshake**
  - A word is accepted when `in_valid && in_ready` are both high.
  - `in_ready = !pend_full`. It does not depend combinationally on `in_valid`.
- **First word of a batch**
  - This is the first accepted word after reset or after a BATCH_END bit.
  - `mask` captures `in_lane_mask` in the cycle that word moves from `pend` into `sh`.
- **States**
  - IDLE: `sh` is empty.
    - If `pend_full`: load `sh` from `pend`, set `bc = B-1`, and go to SHIFT.
  - SHIFT: emits one bit per cycle.
    - Outputs are `bdu_q_bit = sh.q[bc]`, `bdu_r_bit[i] = sh.r[i][bc]`, `bdu_b = bc`, and `bdu_valid = mask`.
    - Code is START when `bc == B-1` and first-of-batch is set. Otherwise MID, except on `bc == 0`, where it is DIM_END or BATCH_END according to `sh.last`.
    - On `bc == 0` with `!sh.last`: if `pend_full`, reload `sh` from `pend` in the same cycle, with no bubble, and stay in SHIFT. Otherwise go to IDLE.
    - On `bc == 0` with `sh.last`: go to WAIT_DONE. `pend` is not transferred.
  - WAIT_DONE: `bdu_valid = 0`.
    - `pend` may still fill.
    - When `batch_done` is seen, go to IDLE. Any waiting word starts in the following cycle.
- **Buffer updates**
  - When `pend` empties into `sh` in the same cycle a new word is accepted, the new word takes `pend`. Both are allowed together.
- **`batch_done` outside WAIT_DONE**
  - It is ignored.
- **Outputs outside SHIFT**
  - `bdu_valid = 0`.
  - `bdu_q_bit`, `bdu_r_bit`, `bdu_code`, and `bdu_b` are driven to 0.

## Timing
- **Reset (`rst == 0` at a clock edge)**
  - State is IDLE. `pend`, `sh`, `mask`, and `bc` are cleared.
  - All outputs are 0, including `in_ready` and `busy`.
  - `in_ready` rises in the first cycle after `rst` returns high.
  - A reset mid-shift or mid-WAIT_DONE discards all buffered words. No partial stream resumes.
- **Latency into an empty feeder**
  - Word accepted at edge t.
  - The MSB appears on the outputs in cycle t+1 (`pend` to `sh` at edge t+1) and the LSB in cycle t+B.
- **Throughput**
  - One dimension per B cycles with zero gap, provided the next word is accepted by the DIM_END cycle.
- **WAIT_DONE**
  - Minimum one cycle, even if `batch_done` coincides with the BATCH_END bit. That pulse is ignored.
- **Outputs**
  - Registered from state and `sh`. No combinational path from inputs to `bdu_*` outputs.

## Test plan
- **Single-dimension batch:** B=8, NUM_BDU=2, mask=11, q=0xA5, r0=0x3C, r1=0xFF, `in_last=1`.
  - q bits 1,0,1,0,0,1,0,1 on cycles t+1..t+8.
  - `r_bit[0]` follows 0,0,1,1,1,1,0,0.
  - Codes: 01, then 00 ×6, then 11.
  - `bdu_b` counts 7..0.
  - Feeder then sits in WAIT_DONE with `bdu_valid=0`.
- **Three-dimension batch, words offered continuously:**
  - 24 consecutive valid cycles.
  - Codes: START once, DIM_END at cycles 8 and 16, BATCH_END at 24.
  - `in_ready` toggles so that `pend` never overflows.
- **Batch stalled on done, next batch already pending:**
  - Next-batch word accepted during WAIT_DONE.
  - `batch_done` pulsed 5 cycles after BATCH_END; next START appears 2 cycles after the pulse.
  - A `batch_done` pulse during SHIFT has no effect.
- **Lane mask:**
  - Batch 1 with mask=01, batch 2 with mask=10.
  - `bdu_valid` is 01 for all of batch 1 and 10 for all of batch 2.
  - Changing `in_lane_mask` mid-batch has no effect.
- **Back-pressure:**
  - `in_valid` held high with `pend` full: `in_ready=0`, no word lost or duplicated.
  - Scoreboard compares the serialized words against the sent words.
- **Reset mid-operation:**
  - `rst=0` at bit 3 of dimension 2 with `pend` full.
  - Next cycle: all outputs 0.
  - After release, a fresh batch begins with START and no stale bits.
